// File: rtl/seq_det_ctrl_if.sv
// Word handshake between an upstream producer and seq_det_ctrl.
// The master drives valid/data and the slave returns ready.
interface seq_det_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_det_ctrl.sv
// Frame controller for the serial "0110" detector: serialises words MSB-first,
// keeps the detector in reset outside RUN and counts its matches per frame.
module seq_det_ctrl #(
   parameter int DATA_W    = 8,
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   seq_det_ctrl_if.slave    word,
   output logic             det_a,
   output logic             det_rst,
   input  logic             det_out,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] match_cnt,
   output logic             underrun
);

   localparam int WC_W = $clog2(FRAME_LEN + 1);
   localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state;
   logic [DATA_W-1:0] hold;
   logic              hold_valid;
   logic [DATA_W-1:0] shreg;
   logic [BC_W-1:0]   bit_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [WC_W-1:0]   accepted;
   logic              accept;

   assign busy          = (state == FILL) || (state == RUN);
   assign det_rst       = (state != RUN);
   assign det_a         = (state == RUN) ? shreg[DATA_W-1] : 1'b0;
   assign word.in_ready = busy && !hold_valid && (accepted < WC_W'(FRAME_LEN));
   assign accept        = word.in_valid && word.in_ready;
   // An abort arriving in the DONE cycle suppresses the completion pulse.
   assign frame_done    = (state == DONE) && !abort;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         hold       <= '0;
         hold_valid <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         accepted   <= '0;
         match_cnt  <= '0;
         underrun   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FILL;
                  match_cnt <= '0;
                  underrun  <= 1'b0;
                  accepted  <= '0;
                  word_cnt  <= '0;
               end
            end
            FILL: begin
               if (hold_valid) begin
                  shreg      <= hold;
                  hold_valid <= 1'b0;
                  bit_cnt    <= BC_W'(DATA_W - 1);
                  state      <= RUN;
               end
            end
            RUN: begin
               shreg   <= shreg << 1;
               bit_cnt <= bit_cnt - 1'b1;
               if (det_out && (match_cnt != '1)) begin
                  match_cnt <= match_cnt + 1'b1;
               end
               if (bit_cnt == '0) begin
                  if (word_cnt == WC_W'(FRAME_LEN - 1)) begin
                     state <= DONE;
                  end else if (hold_valid) begin
                     // Seamless reload: the detector keeps its state across words.
                     shreg      <= hold;
                     hold_valid <= 1'b0;
                     bit_cnt    <= BC_W'(DATA_W - 1);
                     word_cnt   <= word_cnt + 1'b1;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                     underrun <= 1'b1;
                     state    <= FILL;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            hold       <= word.in_data;
            hold_valid <= 1'b1;
            accepted   <= accepted + 1'b1;
         end

         if (abort) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: behavioural "0110" detectors close the loop and a
// scoreboard of expected frame results is checked at every frame_done.
module tb_seq_det_ctrl;

   typedef struct {
      int cnt;
      bit und;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] wq[$];
   int         checks = 0;
   int         errors = 0;
   int         run1   = 0;
   int         done1  = 0;

   logic clk = 1'b0;
   logic reset, start, start2, abort;

   logic        det_a1, det_rst1, det_out1, busy1, frame_done1, underrun1;
   logic [15:0] cnt1;
   logic        det_a2, det_rst2, det_out2, busy2, frame_done2, underrun2;
   logic [1:0]  cnt2;
   logic [1:0]  ds1, ds2;

   seq_det_ctrl_if #(.DATA_W(8)) bus1 ();
   seq_det_ctrl_if #(.DATA_W(8)) bus2 ();

   seq_det_ctrl #(.DATA_W(8), .FRAME_LEN(4), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .word(bus1),
      .det_a(det_a1), .det_rst(det_rst1), .det_out(det_out1), .busy(busy1),
      .frame_done(frame_done1), .match_cnt(cnt1), .underrun(underrun1)
   );

   seq_det_ctrl #(.DATA_W(8), .FRAME_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort), .word(bus2),
      .det_a(det_a2), .det_rst(det_rst2), .det_out(det_out2), .busy(busy2),
      .frame_done(frame_done2), .match_cnt(cnt2), .underrun(underrun2)
   );

   always #5 clk = ~clk;

   // Mealy "0110" detector, overlapping: 0=none,1="0",2="01",3="011".
   function automatic logic [1:0] det_next(input logic [1:0] s, input logic a);
      case (s)
         2'd0:    det_next = a ? 2'd0 : 2'd1;
         2'd1:    det_next = a ? 2'd2 : 2'd1;
         2'd2:    det_next = a ? 2'd3 : 2'd1;
         default: det_next = a ? 2'd0 : 2'd1;
      endcase
   endfunction

   always @(posedge clk) ds1 <= det_rst1 ? 2'd0 : det_next(ds1, det_a1);
   always @(posedge clk) ds2 <= det_rst2 ? 2'd0 : det_next(ds2, det_a2);
   assign det_out1 = (ds1 == 2'd3) && !det_a1;
   assign det_out2 = (ds2 == 2'd3) && !det_a2;

   always @(posedge clk) begin
      if (!det_rst1) run1 <= run1 + 1;
      if (frame_done1) done1 <= done1 + 1;
   end

   function automatic logic rdy(input int sel);
      return (sel == 1) ? bus1.in_ready : bus2.in_ready;
   endfunction

   task automatic set_valid(input int sel, input logic v, input logic [7:0] d);
      if (sel == 1) begin
         bus1.in_valid = v;
         bus1.in_data  = d;
      end else begin
         bus2.in_valid = v;
         bus2.in_data  = d;
      end
   endtask

   task automatic pulse_start(input int sel);
      @(negedge clk);
      if (sel == 1) start = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic send_words(input int sel, input int gap_idx, input int gap);
      for (int i = 0; i < wq.size(); i++) begin
         bit acc = 1'b0;
         if (i == gap_idx) repeat (gap) @(negedge clk);
         set_valid(sel, 1'b1, wq[i]);
         for (int k = 0; k < 100 && !acc; k++) begin
            if (rdy(sel)) begin
               @(posedge clk);
               acc = 1'b1;
            end
            @(negedge clk);
         end
         set_valid(sel, 1'b0, 8'h00);
         checks++;
         if (!acc) begin
            errors++;
            $display("FAIL send_word%0d: accepted=0, required accepted=1 within 100 cycles", i);
         end
      end
   endtask

   task automatic wait_done(input int sel, input string name);
      bit   seen = 1'b0;
      exp_t e;
      int   got_cnt;
      logic got_und;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if ((sel == 1) ? frame_done1 : frame_done2) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done: frame_done=0, required a pulse within 400 cycles", name);
      end
      e       = sb.pop_front();
      got_cnt = (sel == 1) ? int'(cnt1) : int'(cnt2);
      got_und = (sel == 1) ? underrun1 : underrun2;
      checks++;
      if (got_cnt !== e.cnt) begin
         errors++;
         $display("FAIL %s_match_cnt: got %0d, required %0d", name, got_cnt, e.cnt);
      end
      checks++;
      if (got_und !== e.und) begin
         errors++;
         $display("FAIL %s_underrun: got %0b, required %0b", name, got_und, e.und);
      end
   endtask

   task automatic wait_run(input int base, input int n);
      for (int k = 0; k < 200 && (run1 - base) < n; k++) @(negedge clk);
      checks++;
      if ((run1 - base) < n) begin
         errors++;
         $display("FAIL wait_run: run cycles %0d, required %0d", run1 - base, n);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (cnt1 !== 16'd0)   begin errors++; $display("FAIL rst_match_cnt: got %0d, required 0", cnt1); end
      checks++; if (underrun1 !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b, required 0", underrun1); end
      checks++; if (frame_done1 !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b, required 0", frame_done1); end
      checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus1.in_ready); end
      checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b, required 0", busy1); end
      checks++; if (det_a1 !== 1'b0)  begin errors++; $display("FAIL rst_det_a: got %b, required 0", det_a1); end
      checks++; if (det_rst1 !== 1'b1) begin errors++; $display("FAIL rst_det_rst: got %b, required 1", det_rst1); end
      checks++; if (cnt2 !== 2'd0)    begin errors++; $display("FAIL rst_match_cnt2: got %0d, required 0", cnt2); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int rb, db;
      wq = '{8'h66, 8'h66, 8'h66, 8'h66};
      sb.push_back('{cnt: 8, und: 1'b0});
      rb = run1;
      db = done1;
      pulse_start(1);
      checks++;
      if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_fill: busy=%b, required 1", busy1); end
      fork
         send_words(1, -1, 0);
         wait_done(1, "b2b");
      join
      repeat (3) @(negedge clk);
      checks++;
      if (run1 - rb != 32) begin errors++; $display("FAIL b2b_run_cycles: got %0d, required 32", run1 - rb); end
      checks++;
      if (done1 - db != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d, required 1", done1 - db); end
   endtask

   task automatic test_boundary();
      wq = '{8'h03, 8'h7F, 8'h00, 8'h00};
      sb.push_back('{cnt: 1, und: 1'b0});
      pulse_start(1);
      fork
         send_words(1, -1, 0);
         wait_done(1, "boundary");
      join
      repeat (2) @(negedge clk);
   endtask

   task automatic test_underrun();
      int rb;
      wq = '{8'h03, 8'h7F, 8'h00, 8'h00};
      sb.push_back('{cnt: 0, und: 1'b1});
      rb = run1;
      pulse_start(1);
      fork
         send_words(1, 1, 12);
         wait_done(1, "underrun");
         begin
            wait_run(rb, 8);
            checks++;
            if (det_rst1 !== 1'b1 || busy1 !== 1'b1) begin
               errors++;
               $display("FAIL gap_det_rst: det_rst=%b busy=%b, required 1 1", det_rst1, busy1);
            end
         end
      join
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturate();
      wq = '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66};
      sb.push_back('{cnt: 3, und: 1'b0});
      pulse_start(2);
      fork
         send_words(2, -1, 0);
         wait_done(2, "saturate");
      join
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      int rb, db;
      set_valid(1, 1'b1, 8'h66);
      rb = run1;
      pulse_start(1);
      wait_run(rb, 10);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      set_valid(1, 1'b0, 8'h00);
      db = done1;
      checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %b, required 0", busy1); end
      checks++; if (det_rst1 !== 1'b1) begin errors++; $display("FAIL abort_det_rst: got %b, required 1", det_rst1); end
      checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b, required 0", bus1.in_ready); end
      checks++; if (cnt1 !== 16'd2)   begin errors++; $display("FAIL abort_cnt_kept: got %0d, required 2", cnt1); end
      repeat (10) @(negedge clk);
      checks++; if (done1 != db)      begin errors++; $display("FAIL abort_no_done: got %0d pulses, required 0", done1 - db); end
      pulse_start(1);
      checks++; if (cnt1 !== 16'd0)   begin errors++; $display("FAIL restart_cnt: got %0d, required 0", cnt1); end
      checks++; if (busy1 !== 1'b1)   begin errors++; $display("FAIL restart_busy: got %b, required 1", busy1); end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_async_reset();
      int rb;
      set_valid(1, 1'b1, 8'h66);
      rb = run1;
      pulse_start(1);
      wait_run(rb, 6);
      #2 reset = 1'b0;
      #1;
      checks++; if (det_rst1 !== 1'b1) begin errors++; $display("FAIL areset_det_rst: got %b, required 1", det_rst1); end
      checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL areset_busy: got %b, required 0", busy1); end
      checks++; if (cnt1 !== 16'd0)   begin errors++; $display("FAIL areset_cnt: got %0d, required 0", cnt1); end
      checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready: got %b, required 0", bus1.in_ready); end
      checks++; if (det_a1 !== 1'b0)  begin errors++; $display("FAIL areset_det_a: got %b, required 0", det_a1); end
      set_valid(1, 1'b0, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int rb;
      wq = '{8'h66, 8'h66, 8'h66, 8'h66};
      sb.push_back('{cnt: 8, und: 1'b0});
      rb = run1;
      pulse_start(1);
      fork
         send_words(1, -1, 0);
         wait_done(1, "start_ignored");
         begin
            wait_run(rb, 12);
            pulse_start(1);
         end
      join
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      abort  = 1'b0;
      set_valid(1, 1'b0, 8'h00);
      set_valid(2, 1'b0, 8'h00);
      test_reset();
      test_back_to_back();
      test_boundary();
      test_underrun();
      test_saturate();
      test_abort();
      test_async_reset();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
